// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data port, shared memory port and status.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
);
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic          IAck;
  logic [DW-1:0] IRdData;
  logic          DReq;
  logic          DWe;
  logic [AW-1:0] DAddr;
  logic [DW-1:0] DWrData;
  logic          DAck;
  logic [DW-1:0] DRdData;
  logic          IStall;
  logic          DStall;
  logic          MemEn;
  logic          MemWe;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWrData;
  logic [DW-1:0] MemRdData;
  logic [CW-1:0] ConflictCnt;

  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWrData, MemRdData,
    output IAck, IRdData, DAck, DRdData, IStall, DStall,
           MemEn, MemWe, MemAddr, MemWrData, ConflictCnt
  );

  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWrData, MemRdData,
    input  IAck, IRdData, DAck, DRdData, IStall, DStall,
           MemEn, MemWe, MemAddr, MemWrData, ConflictCnt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between the fetch (I) and data (D) ports,
// turning level requests into fixed-latency acked accesses with D priority and alternation.
//
// state  | meaning
// IDLE   | no access in flight; grant D first, else I
// ACCESS | memory enabled with the latched owner's address/data
// RESP   | owner's Ack high; grant the other port if it is requesting
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input logic          Clk,
  input logic          Rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          ownerD;
  logic          latWe;
  logic          iAckQ;
  logic          dAckQ;
  logic          memEnQ;
  logic          memWeQ;
  logic [AW-1:0] memAddrQ;
  logic [DW-1:0] memWrDataQ;
  logic [DW-1:0] iRdHold;
  logic [DW-1:0] dRdHold;
  logic [CW-1:0] conflictQ;
  logic          grantD;
  logic          grantI;
  logic          iStall;
  logic          dStall;

  assign iStall = bus.IReq & ~iAckQ;
  assign dStall = bus.DReq & ~dAckQ;

  // In RESP only the non-owner may be granted.
  always_comb begin
    grantD = 1'b0;
    grantI = 1'b0;
    case (state)
      IDLE: begin
        grantD = bus.DReq;
        grantI = bus.IReq & ~bus.DReq;
      end
      RESP: begin
        grantD = ~ownerD & bus.DReq;
        grantI = ownerD & bus.IReq;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state      <= IDLE;
      ownerD     <= 1'b0;
      latWe      <= 1'b0;
      iAckQ      <= 1'b0;
      dAckQ      <= 1'b0;
      memEnQ     <= 1'b0;
      memWeQ     <= 1'b0;
      memAddrQ   <= '0;
      memWrDataQ <= '0;
      iRdHold    <= '0;
      dRdHold    <= '0;
      conflictQ  <= '0;
    end else begin
      iAckQ  <= 1'b0;
      dAckQ  <= 1'b0;
      memEnQ <= 1'b0;
      memWeQ <= 1'b0;

      if (iStall && dStall && !(&conflictQ))
        conflictQ <= conflictQ + CW'(1);

      case (state)
        ACCESS: begin
          state <= RESP;
          if (ownerD) dAckQ <= 1'b1;
          else        iAckQ <= 1'b1;
        end
        RESP: begin
          if (!latWe) begin
            if (ownerD) dRdHold <= bus.MemRdData;
            else        iRdHold <= bus.MemRdData;
          end
        end
        default: ;
      endcase

      if (state != ACCESS) begin
        if (grantD || grantI) begin
          state    <= ACCESS;
          ownerD   <= grantD;
          latWe    <= grantD & bus.DWe;
          memEnQ   <= 1'b1;
          memWeQ   <= grantD & bus.DWe;
          memAddrQ <= grantD ? bus.DAddr : bus.IAddr;
          if (grantD) memWrDataQ <= bus.DWrData;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

  // The memory output is itself a register; presenting it during the ack cycle keeps
  // RdData coincident with Ack, and the hold register keeps it afterwards.
  assign bus.IRdData     = (iAckQ && !latWe) ? bus.MemRdData : iRdHold;
  assign bus.DRdData     = (dAckQ && !latWe) ? bus.MemRdData : dRdHold;
  assign bus.IAck        = iAckQ;
  assign bus.DAck        = dAckQ;
  assign bus.IStall      = iStall;
  assign bus.DStall      = dStall;
  assign bus.MemEn       = memEnQ;
  assign bus.MemWe       = memWeQ;
  assign bus.MemAddr     = memAddrQ;
  assign bus.MemWrData   = memWrDataQ;
  assign bus.ConflictCnt = conflictQ;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand-written corner sequences,
// and a randomized phase scored against a transaction-level memory model.
module tb_mem_arbiter;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  mem_arbiter_if #(.AW(32), .DW(32), .CW(16)) bus ();

  mem_arbiter #(.AW(32), .DW(32), .CW(16)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Memory device: one-cycle registered read.
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    mem[4] = 32'h8C01_0004;
    bus.MemRdData = '0;
    forever begin
      @(posedge Clk);
      if (bus.MemEn) begin
        if (bus.MemWe) mem[bus.MemAddr[9:2]] <= bus.MemWrData;
        else           bus.MemRdData <= mem[bus.MemAddr[9:2]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        isD;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expI;
    logic [31:0] expD;
  } vec_t;

  vec_t tbl [9];

  // Random-phase model state
  logic [31:0] refMem [256];
  logic [31:0] expI, expD;
  logic [15:0] modelCnt;
  logic        iPend, dPend;
  int          iStart, dStart, cyc;

  task automatic rnd_cycle(input bit allowNew);
    @(negedge Clk);
    cyc++;
    if (bus.IAck) begin
      check("i_ack_pending", iPend, 1);
      check("i_latency", 32'((cyc - iStart >= 2) && (cyc - iStart <= 5)), 1);
      expI = refMem[bus.IAddr[9:2]];
      iPend = 1'b0;
    end else if (iPend && (cyc - iStart > 5)) begin
      check("i_ack_timeout", bus.IAck, 1);
      iPend = 1'b0;
    end
    if (bus.DAck) begin
      check("d_ack_pending", dPend, 1);
      check("d_latency", 32'((cyc - dStart >= 2) && (cyc - dStart <= 5)), 1);
      if (bus.DWe) refMem[bus.DAddr[9:2]] = bus.DWrData;
      else         expD = refMem[bus.DAddr[9:2]];
      dPend = 1'b0;
    end else if (dPend && (cyc - dStart > 5)) begin
      check("d_ack_timeout", bus.DAck, 1);
      dPend = 1'b0;
    end
    check("rnd_IRdData", bus.IRdData, expI);
    check("rnd_DRdData", bus.DRdData, expD);
    check("rnd_ConflictCnt", bus.ConflictCnt, modelCnt);
    check("rnd_we_without_en", bus.MemWe & ~bus.MemEn, 0);
    check("rnd_dual_ack", bus.IAck & bus.DAck, 0);
    check("rnd_IStall", bus.IStall, bus.IReq & ~bus.IAck);
    check("rnd_DStall", bus.DStall, bus.DReq & ~bus.DAck);

    if (!iPend) begin
      if (allowNew && $urandom_range(0, 2) == 0) begin
        bus.IReq  = 1'b1;
        bus.IAddr = 32'h100 + 32'(4 * $urandom_range(0, 15));
        iPend = 1'b1;
        iStart = cyc;
      end else bus.IReq = 1'b0;
    end
    if (!dPend) begin
      if (allowNew && $urandom_range(0, 2) == 0) begin
        bus.DReq    = 1'b1;
        bus.DWe     = 1'($urandom_range(0, 1));
        bus.DAddr   = 32'h100 + 32'(4 * $urandom_range(0, 15));
        bus.DWrData = $urandom;
        dPend = 1'b1;
        dStart = cyc;
      end else bus.DReq = 1'b0;
    end
    if (bus.IReq && !bus.IAck && bus.DReq && !bus.DAck && modelCnt != 16'hFFFF)
      modelCnt++;
  endtask

  initial begin
    int expCnt;
    bus.IReq = 1'b1; bus.IAddr = 32'h0;
    bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h0; bus.DWrData = 32'h0;

    tbl[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'h8C01_0004, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h8C01_0004, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h20, 32'h0,         32'h8C01_0004, 32'hDEAD_BEEF};
    tbl[3] = '{1'b0, 1'b0, 32'h20, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[4] = '{1'b1, 1'b1, 32'h44, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[5] = '{1'b0, 1'b0, 32'h44, 32'h0,         32'h1234_5678, 32'hDEAD_BEEF};
    tbl[6] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h1234_5678, 32'h8C01_0004};
    tbl[7] = '{1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, 32'h1234_5678, 32'h8C01_0004};
    tbl[8] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hCAFE_F00D, 32'h8C01_0004};

    // Reset with both requests high
    repeat (2) @(negedge Clk);
    check("rst_MemEn", bus.MemEn, 0);
    check("rst_IAck", bus.IAck, 0);
    check("rst_DAck", bus.DAck, 0);
    check("rst_ConflictCnt", bus.ConflictCnt, 0);
    check("rst_IRdData", bus.IRdData, 0);
    check("rst_DRdData", bus.DRdData, 0);
    check("rst_MemAddr", bus.MemAddr, 0);
    Rst = 1'b1; bus.IReq = 1'b0; bus.DReq = 1'b0;
    @(negedge Clk);

    // Single-requester vectors
    for (int v = 0; v < 9; v++) begin
      if (tbl[v].isD) begin
        bus.DReq = 1'b1; bus.DWe = tbl[v].we; bus.DAddr = tbl[v].addr; bus.DWrData = tbl[v].wdata;
      end else begin
        bus.IReq = 1'b1; bus.IAddr = tbl[v].addr;
      end
      @(negedge Clk);
      check("vec_access_MemEn", bus.MemEn, 1);
      check("vec_access_MemWe", bus.MemWe, tbl[v].we);
      check("vec_access_MemAddr", bus.MemAddr, tbl[v].addr);
      if (tbl[v].we) check("vec_access_MemWrData", bus.MemWrData, tbl[v].wdata);
      check("vec_access_noack", bus.IAck | bus.DAck, 0);
      @(negedge Clk);
      check("vec_resp_IAck", bus.IAck, !tbl[v].isD);
      check("vec_resp_DAck", bus.DAck, tbl[v].isD);
      check("vec_resp_MemEn", bus.MemEn, 0);
      check("vec_resp_MemWe", bus.MemWe, 0);
      check("vec_resp_IRdData", bus.IRdData, tbl[v].expI);
      check("vec_resp_DRdData", bus.DRdData, tbl[v].expD);
      bus.IReq = 1'b0; bus.DReq = 1'b0;
      @(negedge Clk);
      check("vec_idle_acks", bus.IAck | bus.DAck, 0);
      check("vec_idle_MemEn", bus.MemEn, 0);
      check("vec_hold_IRdData", bus.IRdData, tbl[v].expI);
      check("vec_hold_DRdData", bus.DRdData, tbl[v].expD);
    end

    // Contention: both held for 10 cycles
    check("cont_base_cnt", bus.ConflictCnt, 0);
    bus.IReq = 1'b1; bus.IAddr = 32'h10;
    bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h20;
    expCnt = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      check("cont_DAck", bus.DAck, (k % 4) == 2);
      check("cont_IAck", bus.IAck, (k % 4) == 0);
      check("cont_MemEn", bus.MemEn, (k % 2) == 1);
      check("cont_ConflictCnt", bus.ConflictCnt, expCnt);
      if (k % 2 == 1) check("cont_MemAddr", bus.MemAddr, ((k % 4) == 1) ? 32'h20 : 32'h10);
      if (k % 4 == 2) check("cont_DRdData", bus.DRdData, 32'hDEAD_BEEF);
      if (k % 4 == 0) check("cont_IRdData", bus.IRdData, 32'hCAFE_F00D);
      if ((k % 2) == 1) expCnt++;
    end
    bus.IReq = 1'b0; bus.DReq = 1'b0;
    @(negedge Clk);
    check("cont_end_MemEn", bus.MemEn, 0);
    check("cont_end_cnt", bus.ConflictCnt, expCnt);

    // Withdrawal during ACCESS
    bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h44;
    @(negedge Clk);
    check("wd_MemEn", bus.MemEn, 1);
    bus.DReq = 1'b0; bus.DAddr = 32'h20;
    @(negedge Clk);
    check("wd_DAck", bus.DAck, 1);
    check("wd_DRdData", bus.DRdData, 32'h1234_5678);
    @(negedge Clk);
    check("wd_after_DAck", bus.DAck, 0);
    check("wd_after_MemEn", bus.MemEn, 0);
    @(negedge Clk);
    check("wd_idle_MemEn", bus.MemEn, 0);

    // Reset while in ACCESS
    bus.IReq = 1'b1; bus.IAddr = 32'h44;
    @(negedge Clk);
    check("ra_MemEn", bus.MemEn, 1);
    Rst = 1'b0;
    @(negedge Clk);
    check("ra_IAck", bus.IAck, 0);
    check("ra_MemEn", bus.MemEn, 0);
    check("ra_IRdData", bus.IRdData, 0);
    bus.IReq = 1'b0; Rst = 1'b1;
    @(negedge Clk);
    check("ra_idle_IAck", bus.IAck, 0);
    check("ra_idle_MemEn", bus.MemEn, 0);
    bus.DReq = 1'b1; bus.DWe = 1'b0; bus.DAddr = 32'h20;
    @(negedge Clk);
    check("ra_regrant_MemEn", bus.MemEn, 1);
    check("ra_regrant_MemAddr", bus.MemAddr, 32'h20);
    bus.DReq = 1'b0;
    @(negedge Clk);
    check("ra_regrant_DAck", bus.DAck, 1);
    check("ra_regrant_DRdData", bus.DRdData, 32'hDEAD_BEEF);

    // Randomized traffic against the transaction-level model
    Rst = 1'b0; bus.IReq = 1'b0; bus.DReq = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    for (int i = 0; i < 256; i++) refMem[i] = mem[i];
    expI = '0; expD = '0; modelCnt = '0;
    iPend = 1'b0; dPend = 1'b0; iStart = 0; dStart = 0; cyc = 0;
    for (int n = 0; n < 3000; n++) rnd_cycle(1'b1);
    for (int n = 0; n < 12; n++) rnd_cycle(1'b0);
    check("rnd_i_drained", iPend, 0);
    check("rnd_d_drained", dPend, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares one single-port synchronous memory between the pipeline's instruction-fetch port (I) and data-memory port (D). It sits between the Fetch/Memory stages and a unified memory with one-cycle registered read latency. It converts level requests into fixed-latency acknowledged transactions and exports stall signals the pipeline uses to freeze.

## Interface
- AW, 32, address width in bits; addresses pass through unchanged.
- DW, 32, data width in bits.
- CW, 16, width of the conflict counter.
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  reset, synchronous, active-low.
- IReq  in  1  fetch read request, level; held until IAck.
- IAddr  in  AW  fetch address.
- IAck  out  1  one-cycle pulse: fetch read complete.
- IRdData  out  DW  fetch read data; registered.
- DReq  in  1  data request, level; held until DAck.
- DWe  in  1  1 = write, 0 = read.
- DAddr  in  AW  data address.
- DWrData  in  DW  data write value.
- DAck  out  1  one-cycle pulse: data access complete.
- DRdData  out  DW  data read result; registered.
- IStall  out  1  IReq & ~IAck, combinational.
- DStall  out  1  DReq & ~DAck, combinational.
- MemEn  out  1  memory access enable.
- MemWe  out  1  memory write enable; only meaningful with MemEn.
- MemAddr  out  AW  memory address.
- MemWrData  out  DW  memory write data.
- MemRdData  in  DW  memory read data; valid the cycle after a read with MemEn=1.
- ConflictCnt  out  CW  saturating count of cycles with both IStall and DStall high.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If DReq, grant D; else if IReq, grant I; else stay in IDLE.
  - On a grant, latch the owner, address, We (forced to 0 for I) and write data, then go to ACCESS.
- ACCESS:
  - MemEn=1; MemWe, MemAddr and MemWrData driven from the latched values.
  - Always go to RESP next.
- RESP:
  - Pulse the owner's Ack.
  - A read loads the owner's RdData from MemRdData. A write leaves both RdData registers unchanged.
  - Re-arbitrate over the non-owner's request only; the owner's Req is ignored this cycle.
  - If the non-owner is requesting, latch it and go to ACCESS; otherwise go to IDLE.
- Consequence: when both ports request continuously they alternate grants. Neither port can starve.
- Request inputs are sampled only at a grant. Deasserting Req or changing the address after the grant does not affect the in-flight transaction, and its Ack still pulses.
- RdData registers hold their value until the next read ack for that port.
- ConflictCnt increments by 1 in every cycle where IStall and DStall are both high. It saturates at all-ones.
- Outputs when not in ACCESS: MemEn=0, MemWe=0, MemAddr and MemWrData hold the last latched values.

## Timing
- Reset (Rst=0 at an edge):
  - State IDLE; IAck, DAck, MemEn, MemWe = 0; IRdData, DRdData, MemAddr, MemWrData, ConflictCnt = 0; latched owner = I.
- Reset mid-transaction:
  - The transaction is abandoned, no Ack is produced, and MemEn is 0 from the next cycle.
  - A write already issued in ACCESS is not undone.
- Latency: Req high in IDLE during cycle N gives MemEn in N+1 and Ack in N+2.
- Throughput:
  - Single requester: one access per 3 cycles (IDLE, ACCESS, RESP).
  - Alternating requesters: one access per 2 cycles.
- Simultaneous IReq and DReq in IDLE: D wins. I is granted from D's RESP cycle and acked 2 cycles later.
- Ack and RdData update in the same cycle.
- MemWe is never 1 in a cycle where MemEn is 0.

## Test plan
- Reset: hold Rst=0 for 2 cycles with IReq=DReq=1 -> MemEn, IAck, DAck = 0; ConflictCnt = 0; IRdData = DRdData = 0.
- Single fetch: IReq=1, IAddr=0x10, memory returns 0x8C010004 -> MemEn=1 with MemAddr=0x10 at N+1; IAck pulse and IRdData=0x8C010004 at N+2; returns to IDLE.
- Data write then read: DWe=1, DAddr=0x20, DWrData=0xDEADBEEF, then DWe=0 at the same address -> MemWe=1 only in the write ACCESS cycle; DRdData unchanged after the write ack; DRdData=0xDEADBEEF after the read ack.
- Contention: IReq and DReq both held high for 10 cycles -> grants alternate D, I, D, I with Acks 2 cycles apart; ConflictCnt increments only in cycles where neither Ack is high.
- Withdrawal: DReq dropped in the ACCESS cycle -> DAck still pulses in RESP and the FSM returns to IDLE.
- Reset in ACCESS: Rst=0 while MemEn=1 -> no Ack pulse; next cycle MemEn=0 and state is IDLE.
